incomp_if_checker: RTL and testbench
====================================

Name: incomp_if_checker

Overview:
- Synthesizable response checker for the incomplete-if / inferred-latch demo blocks.
- Samples the stimulus (enable i0, data i1) and the DUT output y each clock and compares y against an internal golden latch model: y follows i1 while i0=1, holds otherwise.
- Counts mismatches over a programmable window and reports pass/fail, so latch-inference results are checked in RTL, on FPGA or in gate-level sim, instead of by reading a VCD.

Parameters:
- WIN_W, 12, width of the sample-window counter; max window is 2^WIN_W-1 cycles.
- SETTLE, 4, cycles ignored after start before comparison begins (DUT/stimulus settling).
- ERR_W, 8, width of the mismatch counter; saturates at all-ones.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a check run; ignored unless state is IDLE or DONE.
- win_len  input  WIN_W  number of compared samples per run; sampled at start.
- i0  input  1  observed latch enable (stimulus), synchronous to clk.
- i1  input  1  observed latch data (stimulus), synchronous to clk.
- y_dut  input  1  DUT output under check.
- busy  output  1  high in ARM or RUN.
- done  output  1  high in DONE; held until next start or reset.
- pass  output  1  valid when done=1: 1 iff err_cnt==0.
- err_cnt  output  ERR_W  mismatch count of the current/last run (saturating).
- first_err_vld  output  1  a mismatch has been recorded this run.
- first_err_idx  output  WIN_W  sample index (0-based, RUN cycles) of the first mismatch.

Behaviour:
- Reset (sync, active-high), all outputs 0: state=IDLE, busy=0, done=0, pass=0, err_cnt=0, first_err_vld=0, first_err_idx=0, model register held_q=0, counters=0. Reset mid-run aborts to IDLE with no done pulse.
- Golden model: exp = i0 ? i1 : held_q (combinational). Every cycle, in all states, held_q <= exp, so the model tracks the stimulus while idle.
- mismatch = (y_dut != exp), evaluated only in RUN.
- FSM:
  - IDLE/DONE: start=1 -> ARM. Clear err_cnt, first_err_vld, first_err_idx, done, pass. Latch win_len into win_q. Load settle counter with SETTLE.
  - ARM: decrement settle counter. When it reaches 0 -> RUN with sample index=0. SETTLE=0 means ARM lasts one cycle.
  - RUN: each cycle compare. On mismatch: err_cnt increments unless all-ones. If first_err_vld==0, set it and capture the current index into first_err_idx. When index==win_q-1 -> DONE after that cycle's compare; otherwise index increments.
  - win_q==0: RUN is skipped; ARM goes directly to DONE with pass=1.
  - DONE: done=1, pass=(err_cnt==0). Stays until start or reset.
- start while busy: ignored; no restart.
- start in the same cycle as reset: reset wins.
- Latency: done asserts 1 + SETTLE + win_q cycles after the start cycle.

Optional Feature:
- Macro INCOMP_CHK_ABORT_EN.
- Defined: the first mismatch in RUN records err_cnt=1, first_err_vld=1 and first_err_idx, then moves to DONE on the next edge (pass=0). No further samples are taken.
- Undefined: runs the full window and counts all mismatches.

Test Plan:
- Reset check: reset high 2 cycles, including a start pulse -> all outputs 0, state IDLE, busy=0.
- Ideal transparent latch: y_dut driven by a reference latch model; i0 toggles every 7 cycles, i1 every 3; SETTLE=4, win_len=100 -> busy for 105 cycles, done=1, pass=1, err_cnt=0, first_err_vld=0.
- Mux DUT (y=i0?i1:0) with i0=0, i1=1 held, held_q=1 before start; win_len=10 -> err_cnt=10, first_err_idx=0, pass=0.
- Single injected error: ideal DUT, y_dut flipped only at RUN index 37 of win_len=50 -> err_cnt=1, first_err_idx=37.
- Saturation and boundaries:
  - ERR_W=8, constant mismatch, win_len=300 -> err_cnt=255.
  - win_len=0 -> done after 1+SETTLE cycles with pass=1.
  - start while busy -> ignored.
  - reset at RUN index 20 -> IDLE, done stays 0.
- INCOMP_CHK_ABORT_EN defined, error injected at index 5 -> DONE on the next edge, err_cnt=1, first_err_idx=5, pass=0.

Source files
------------

// File: rtl/incomp_if_checker.sv
// Response checker for incomplete-if latch demo blocks: compares y_dut against a golden latch model.
// Optional macro INCOMP_CHK_ABORT_EN: stop the run at the first mismatch instead of scanning the full window.
module incomp_if_checker #(
    parameter int WIN_W  = 12,
    parameter int SETTLE = 4,
    parameter int ERR_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIN_W-1:0] win_len,
    input  logic             i0,
    input  logic             i1,
    input  logic             y_dut,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic             first_err_vld,
    output logic [WIN_W-1:0] first_err_idx
);

    localparam int SET_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_RUN,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               r_held;
    logic [WIN_W-1:0]   r_win;
    logic [SET_W-1:0]   r_settle;
    logic [WIN_W-1:0]   r_idx;
    logic [ERR_W-1:0]   r_err;
    logic               r_fvld;
    logic [WIN_W-1:0]   r_fidx;

    logic w_exp;
    logic w_mismatch;
    logic w_last;

    // Golden model of a transparent latch; it runs in every state so it is primed before a run.
    assign w_exp      = i0 ? i1 : r_held;
    assign w_mismatch = (r_state == S_RUN) && (y_dut != w_exp);
    assign w_last     = (r_idx == (r_win - WIN_W'(1)));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) w_state_next = S_ARM;
            end
            S_ARM: begin
                if (r_settle == '0) w_state_next = (r_win == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
`ifdef INCOMP_CHK_ABORT_EN
                if (w_mismatch || w_last) w_state_next = S_DONE;
`else
                if (w_last) w_state_next = S_DONE;
`endif
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_held   <= 1'b0;
            r_win    <= '0;
            r_settle <= '0;
            r_idx    <= '0;
            r_err    <= '0;
            r_fvld   <= 1'b0;
            r_fidx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_held  <= w_exp;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_err    <= '0;
                        r_fvld   <= 1'b0;
                        r_fidx   <= '0;
                        r_win    <= win_len;
                        r_settle <= SET_W'(SETTLE);
                        r_idx    <= '0;
                    end
                end
                S_ARM: begin
                    if (r_settle != '0) r_settle <= r_settle - SET_W'(1);
                    r_idx <= '0;
                end
                S_RUN: begin
                    if (w_mismatch) begin
                        if (!(&r_err)) r_err <= r_err + ERR_W'(1);
                        if (!r_fvld) begin
                            r_fvld <= 1'b1;
                            r_fidx <= r_idx;
                        end
                    end
                    r_idx <= r_idx + WIN_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign busy          = (r_state == S_ARM) || (r_state == S_RUN);
    assign done          = (r_state == S_DONE);
    assign pass          = done && (r_err == '0);
    assign err_cnt       = r_err;
    assign first_err_vld = r_fvld;
    assign first_err_idx = r_fidx;

endmodule

// File: tb/tb_incomp_if_checker.sv
// Directed self-checking bench for incomp_if_checker; honours INCOMP_CHK_ABORT_EN when defined.
module tb_incomp_if_checker;

    localparam int WIN_W  = 12;
    localparam int SETTLE = 4;
    localparam int ERR_W  = 8;
`ifdef INCOMP_CHK_ABORT_EN
    localparam bit ABORT = 1'b1;
`else
    localparam bit ABORT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [WIN_W-1:0] win_len;
    logic             i0;
    logic             i1;
    logic             y_dut;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_cnt;
    logic             first_err_vld;
    logic [WIN_W-1:0] first_err_idx;

    int   vectors     = 0;
    int   miscompares = 0;
    int   mode        = 0;   // 0 ideal latch, 1 mux DUT, 2 inverted latch, 3 prime i0=i1=1
    int   inj_k       = -1;  // RUN index at which y_dut is flipped, -1 for none
    int   t           = 0;
    int   n           = 0;   // edges since the start edge, plus one
    int   bc          = 0;
    logic ref_q       = 1'b0;

    always #5 clk = ~clk;

    incomp_if_checker #(
        .WIN_W (WIN_W),
        .SETTLE(SETTLE),
        .ERR_W (ERR_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .win_len      (win_len),
        .i0           (i0),
        .i1           (i1),
        .y_dut        (y_dut),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .err_cnt      (err_cnt),
        .first_err_vld(first_err_vld),
        .first_err_idx(first_err_idx)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
        $display("check %-20s observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick(input logic st);
        logic ideal;
        case (mode)
            1: begin i0 = 1'b0; i1 = 1'b1; end
            3: begin i0 = 1'b1; i1 = 1'b1; end
            default: begin
                i0 = ((t / 7) % 2) == 1;
                i1 = ((t / 3) % 2) == 1;
            end
        endcase
        ideal = i0 ? i1 : ref_q;
        case (mode)
            1:       y_dut = i0 & i1;
            2:       y_dut = ~ideal;
            default: y_dut = ideal;
        endcase
        if (inj_k >= 0 && n == SETTLE + 2 + inj_k) y_dut = ~y_dut;
        start = st;
        @(posedge clk);
        ref_q = reset ? 1'b0 : ideal;
        t++;
        n++;
        #1;
    endtask

    task automatic start_run(input int wl);
        win_len = WIN_W'(wl);
        n = 0;
        tick(1'b1);
    endtask

    task automatic run_to_done(input int budget, output int busy_cnt);
        busy_cnt = 0;
        for (int k = 0; k < budget && !done; k++) begin
            if (busy) busy_cnt++;
            tick(1'b0);
        end
        check("done_within_budget", 32'(done), 32'd1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; win_len = '0;
        i0 = 1'b0; i1 = 1'b0; y_dut = 1'b0;

        // Reset with a start pulse inside it
        tick(1'b0);
        tick(1'b1);
        reset = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        check("rst_first_vld", 32'(first_err_vld), 32'd0);
        check("rst_first_idx", 32'(first_err_idx), 32'd0);

        // Ideal latch, window 100
        mode = 0; inj_k = -1;
        start_run(100);
        run_to_done(400, bc);
        check("ideal_busy_cycles", 32'(bc), 32'd105);
        check("ideal_latency", 32'(n - 1), 32'd105);
        check("ideal_pass", 32'(pass), 32'd1);
        check("ideal_err_cnt", 32'(err_cnt), 32'd0);
        check("ideal_first_vld", 32'(first_err_vld), 32'd0);

        // Mux DUT with held_q primed to 1
        mode = 3;
        tick(1'b0);
        tick(1'b0);
        mode = 1;
        start_run(10);
        run_to_done(100, bc);
        check("mux_err_cnt", 32'(err_cnt), ABORT ? 32'd1 : 32'd10);
        check("mux_first_idx", 32'(first_err_idx), 32'd0);
        check("mux_first_vld", 32'(first_err_vld), 32'd1);
        check("mux_pass", 32'(pass), 32'd0);
        check("mux_latency", 32'(n - 1), ABORT ? 32'd6 : 32'd15);

        // Single injected error at RUN index 37
        mode = 0; inj_k = 37;
        start_run(50);
        run_to_done(200, bc);
        inj_k = -1;
        check("inj37_err_cnt", 32'(err_cnt), 32'd1);
        check("inj37_first_idx", 32'(first_err_idx), 32'd37);
        check("inj37_pass", 32'(pass), 32'd0);
        check("inj37_latency", 32'(n - 1), ABORT ? 32'd43 : 32'd55);

        // Constant mismatch, saturation
        mode = 2;
        start_run(300);
        run_to_done(600, bc);
        check("sat_err_cnt", 32'(err_cnt), ABORT ? 32'd1 : 32'd255);
        check("sat_first_idx", 32'(first_err_idx), 32'd0);
        check("sat_latency", 32'(n - 1), ABORT ? 32'd6 : 32'd305);

        // Zero-length window
        mode = 0;
        start_run(0);
        run_to_done(50, bc);
        check("win0_latency", 32'(n - 1), 32'd5);
        check("win0_pass", 32'(pass), 32'd1);
        check("win0_err_cnt", 32'(err_cnt), 32'd0);

        // One-sample window
        start_run(1);
        run_to_done(50, bc);
        check("win1_latency", 32'(n - 1), 32'd6);
        check("win1_pass", 32'(pass), 32'd1);

        // Start pulses while busy (ARM and RUN) must be ignored
        start_run(20);
        tick(1'b0);
        tick(1'b0);
        win_len = WIN_W'(5);
        tick(1'b1);
        for (int k = 0; k < 10; k++) tick(1'b0);
        tick(1'b1);
        run_to_done(100, bc);
        check("busy_start_latency", 32'(n - 1), 32'd25);
        check("busy_start_pass", 32'(pass), 32'd1);

        // Reset during RUN index 20
        start_run(50);
        while (n < SETTLE + 2 + 20) tick(1'b0);
        check("pre_rst_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick(1'b0);
        reset = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_err_cnt", 32'(err_cnt), 32'd0);
        for (int k = 0; k < 60; k++) tick(1'b0);
        check("midrst_done_later", 32'(done), 32'd0);
        check("midrst_busy_later", 32'(busy), 32'd0);

`ifdef INCOMP_CHK_ABORT_EN
        // Abort on first mismatch at RUN index 5
        inj_k = 5;
        start_run(50);
        run_to_done(100, bc);
        inj_k = -1;
        check("abort_latency", 32'(n - 1), 32'd11);
        check("abort_err_cnt", 32'(err_cnt), 32'd1);
        check("abort_first_idx", 32'(first_err_idx), 32'd5);
        check("abort_pass", 32'(pass), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
